stuffer_frame_ctrl: RTL and testbench
=====================================

Name: stuffer_frame_ctrl

Overview:
- Per-frame sequencer for the 32-bit 0xFF-escaping byte stuffer in the JPEG compressor output path.
- Gates upstream entropy-coder words into the stuffer and issues its flush at frame end.
- Forwards escaped stuffer words downstream, appends the unescaped EOI marker (FFD9) after the flush completes, and reports the frame byte length.
- Monitors protocol errors (start while busy, drain timeout, words outside a frame).

Parameters:
LEN_WIDTH, 24, width of frame byte counter (saturating)
EOI_MARKER, 16'hFFD9, marker appended after last escaped word
DRAIN_TIMEOUT, 63, max cycles in DRAIN waiting for stf_flush_out
TO_WIDTH, 6, width of timeout counter (must hold DRAIN_TIMEOUT)

Ports:
xclk  in  1  compressor clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  pulse, begins a frame
frame_end  in  1  pulse, coincident with or after last src_stb of frame
src_data  in  32  upstream word, MSB aligned
src_bytes  in  2  valid bytes at src_stb, 0 means 4
src_stb  in  1  upstream word strobe
stf_din  out  32  to stuffer din (registered copy of src_data)
stf_bytes_in  out  2  to stuffer bytes_in
stf_in_stb  out  1  to stuffer in_stb
stf_flush_in  out  1  to stuffer flush_in, one-cycle pulse
stf_d_out  in  32  stuffer output word
stf_bytes_out  in  2  stuffer byte count, 0 means 4
stf_dv  in  1  stuffer output valid
stf_flush_out  in  1  stuffer flush completed
out_data  out  32  downstream word
out_bytes  out  2  downstream byte count, 0 means 4
out_dv  out  1  downstream valid
frame_done  out  1  one-cycle pulse after EOI word
frame_len  out  LEN_WIDTH  bytes in frame including EOI, valid from frame_done until next frame_start
busy  out  1  high in any state except IDLE
err_overrun  out  1  sticky: frame_start while busy
err_timeout  out  1  sticky: DRAIN_TIMEOUT expired
err_stray  out  1  sticky: src_stb outside RUN or stf_dv in IDLE/EOI

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0; counters 0. Reset mid-frame abandons frame, no frame_done. Stuffer must share reset.
- FSM states IDLE, RUN, FLUSH, DRAIN, EOI, DONE.
- IDLE: frame_start -> RUN; clears frame byte counter and all three err flags. frame_end in IDLE ignored.
- RUN: src_stb registered to stf_* with 1-cycle latency (stf_in_stb = src_stb delayed). frame_end -> FLUSH; src_stb coincident with frame_end is forwarded.
- FLUSH: stf_flush_in high exactly this cycle, which is 1 cycle after the last stf_in_stb. Next state DRAIN, timeout counter cleared.
- DRAIN: stf_flush_out -> EOI. Each cycle without it increments the timeout counter; reaching DRAIN_TIMEOUT sets err_timeout and -> EOI.
- EOI: out_data = {EOI_MARKER,16'h0}, out_bytes = 2, out_dv = 1 for one cycle; -> DONE.
- DONE: frame_done = 1, frame_len updated; -> IDLE. A frame_start arriving in DONE sets err_overrun.
- Forwarding: stf_dv in RUN/FLUSH/DRAIN registers to out_data/out_bytes/out_dv, 1-cycle latency. stf_dv coincident with stf_flush_out is forwarded.
- stf_dv in IDLE/EOI: dropped, sets err_stray. EOI and forwarded words never share a cycle.
- Byte count: add stf_bytes_out (0 -> 4) per forwarded word, plus 2 at EOI. Saturate at all-ones and do not wrap.
- frame_start while busy: ignored, sets err_overrun. Frame continues.
- src_stb outside RUN: dropped, sets err_stray.
- out_data/out_bytes hold their last value when out_dv = 0.

Decomposition:
- Shared package: FSM state encoding (3-bit), EOI default constant, byte-count decode function (2-bit to 3-bit, 0 -> 4).
- One natural sub-module, stuffer_byte_counter: saturating accumulator with clear and add-3-bit inputs.
- FSM, forwarding registers and timeout stay in the top.

Test Plan:
- Frame of 3 words (AABBCCDD, 11223344, 55 with bytes=1) then frame_end, stuffer model returning 9 bytes -> stf_flush_in pulse 1 cycle after last stf_in_stb; final out word FFD90000 bytes=2; frame_done with frame_len=11.
- Input word FFFFFFFF x2 through real stuffer -> 16 escaped bytes forwarded, then EOI; frame_len=18; no err flags.
- Stuffer model withholds stf_flush_out -> err_timeout after 63 DRAIN cycles; EOI still emitted; frame_done pulses.
- frame_start during RUN and during DONE -> err_overrun=1; byte count and stream unaffected; flag cleared by the next IDLE frame_start.
- src_stb while IDLE, stf_dv during EOI -> err_stray=1; words not forwarded; out_dv only for the EOI word.
- rst_n low during DRAIN -> asynchronous clear, busy=0 immediately, no frame_done; next frame completes normally with correct frame_len.

Source files
------------

// File: rtl/stuffer_frame_ctrl_pkg.sv
// Shared definitions for the JPEG output byte-stuffer frame sequencer.
package stuffer_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EOI   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // End-of-image marker appended after the last escaped word
  localparam logic [15:0] EOI_DEFAULT    = 16'hFFD9;
  // The EOI word carries two bytes
  localparam logic [1:0]  EOI_BYTES_CODE = 2'd2;
  localparam logic [2:0]  EOI_BYTES      = 3'd2;

  // Byte-count field decode: code 0 stands for a full 4-byte word
  function automatic logic [2:0] decode_bytes(input logic [1:0] code);
    return (code == 2'd0) ? 3'd4 : {1'b0, code};
  endfunction

endpackage

// File: rtl/stuffer_byte_counter.sv
// Saturating frame byte accumulator: synchronous clear, adds 0..7 per cycle.
module stuffer_byte_counter #(
  parameter int unsigned W = 24
) (
  input  logic         xclk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         add_en,
  input  logic [2:0]   add_val,
  output logic [W-1:0] count
);

  logic [W:0] sum;

  // Widened sum so the carry out flags saturation
  always_comb begin
    sum = {1'b0, count} + (W+1)'(add_val);
  end

  // Accumulate, clamping at all-ones instead of wrapping
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (add_en) begin
      count <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/stuffer_frame_ctrl.sv
// Per-frame sequencer around the 0xFF-escaping byte stuffer: gates upstream
// words in, issues the flush, forwards escaped words, appends EOI and reports
// the frame length and protocol errors.
module stuffer_frame_ctrl
  import stuffer_frame_ctrl_pkg::*;
#(
  parameter int unsigned LEN_WIDTH     = 24,
  parameter logic [15:0] EOI_MARKER    = EOI_DEFAULT,
  parameter int unsigned DRAIN_TIMEOUT = 63,
  parameter int unsigned TO_WIDTH      = 6
) (
  input  logic                 xclk,
  input  logic                 rst_n,
  input  logic                 frame_start,
  input  logic                 frame_end,
  input  logic [31:0]          src_data,
  input  logic [1:0]           src_bytes,
  input  logic                 src_stb,
  output logic [31:0]          stf_din,
  output logic [1:0]           stf_bytes_in,
  output logic                 stf_in_stb,
  output logic                 stf_flush_in,
  input  logic [31:0]          stf_d_out,
  input  logic [1:0]           stf_bytes_out,
  input  logic                 stf_dv,
  input  logic                 stf_flush_out,
  output logic [31:0]          out_data,
  output logic [1:0]           out_bytes,
  output logic                 out_dv,
  output logic                 frame_done,
  output logic [LEN_WIDTH-1:0] frame_len,
  output logic                 busy,
  output logic                 err_overrun,
  output logic                 err_timeout,
  output logic                 err_stray
);

  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(DRAIN_TIMEOUT);

  state_t                 state, state_nxt;
  logic [TO_WIDTH-1:0]    to_cnt, to_inc;
  logic                   timeout_hit;
  logic                   src_take;
  logic                   fwd;
  logic                   stray;
  logic                   cnt_clr, cnt_add_en;
  logic [2:0]             cnt_add;
  logic [LEN_WIDTH-1:0]   byte_cnt;

  assign busy = (state != ST_IDLE);

  // Next-state decode plus per-cycle strobes for the datapath
  always_comb begin
    state_nxt   = state;
    timeout_hit = 1'b0;
    to_inc      = to_cnt + TO_WIDTH'(1);
    src_take    = src_stb && (state == ST_RUN);
    fwd         = stf_dv && ((state == ST_RUN) || (state == ST_FLUSH) ||
                             (state == ST_DRAIN));
    stray       = (src_stb && (state != ST_RUN)) ||
                  (stf_dv && ((state == ST_IDLE) || (state == ST_EOI)));
    cnt_clr     = (state == ST_IDLE) && frame_start;
    cnt_add_en  = fwd || (state == ST_EOI);
    cnt_add     = (state == ST_EOI) ? EOI_BYTES : decode_bytes(stf_bytes_out);
    unique case (state)
      ST_IDLE:  if (frame_start) state_nxt = ST_RUN;
      ST_RUN:   if (frame_end)   state_nxt = ST_FLUSH;
      ST_FLUSH: state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (stf_flush_out) begin
          state_nxt = ST_EOI;
        end else if (to_inc == TO_LIMIT) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_EOI;
        end
      end
      ST_EOI:   state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Upstream words to the stuffer with one cycle of latency. The flush pulse
  // is registered off FLUSH so it lands one cycle after the last stf_in_stb
  // even when the final src_stb coincides with frame_end.
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      stf_din      <= '0;
      stf_bytes_in <= '0;
      stf_in_stb   <= 1'b0;
      stf_flush_in <= 1'b0;
    end else begin
      stf_in_stb   <= src_take;
      stf_flush_in <= (state == ST_FLUSH);
      if (src_take) begin
        stf_din      <= src_data;
        stf_bytes_in <= src_bytes;
      end
    end
  end

  // Drain timeout counter, restarted on the way into DRAIN
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ST_FLUSH) begin
      to_cnt <= '0;
    end else if ((state == ST_DRAIN) && !stf_flush_out) begin
      to_cnt <= to_inc;
    end
  end

  // Downstream word register: escaped words, then the EOI word; holds otherwise
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_bytes <= '0;
      out_dv    <= 1'b0;
    end else begin
      out_dv <= 1'b0;
      if (fwd) begin
        out_data  <= stf_d_out;
        out_bytes <= stf_bytes_out;
        out_dv    <= 1'b1;
      end else if (state == ST_EOI) begin
        out_data  <= {EOI_MARKER, 16'h0000};
        out_bytes <= EOI_BYTES_CODE;
        out_dv    <= 1'b1;
      end
    end
  end

  // Frame completion pulse and latched length
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      frame_len  <= '0;
    end else begin
      frame_done <= (state == ST_DONE);
      if (state == ST_DONE) frame_len <= byte_cnt;
    end
  end

  // Sticky error flags, cleared when a new frame is accepted; a set in the
  // same cycle as the clear takes priority
  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      err_stray   <= 1'b0;
    end else begin
      if (cnt_clr) begin
        err_overrun <= 1'b0;
        err_timeout <= 1'b0;
        err_stray   <= 1'b0;
      end
      if (frame_start && busy) err_overrun <= 1'b1;
      if (timeout_hit)         err_timeout <= 1'b1;
      if (stray)               err_stray   <= 1'b1;
    end
  end

  stuffer_byte_counter #(
    .W (LEN_WIDTH)
  ) u_byte_counter (
    .xclk    (xclk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .add_en  (cnt_add_en),
    .add_val (cnt_add),
    .count   (byte_cnt)
  );

endmodule

// File: tb/tb_stuffer_frame_ctrl.sv
// Directed bench for stuffer_frame_ctrl with a behavioural 0xFF-escaping
// stuffer and a scoreboard of expected downstream words and frame lengths.
module tb_stuffer_frame_ctrl;

  logic        xclk = 1'b0;
  logic        rst_n;
  logic        frame_start, frame_end, src_stb;
  logic [31:0] src_data;
  logic [1:0]  src_bytes;
  logic [31:0] stf_din;
  logic [1:0]  stf_bytes_in;
  logic        stf_in_stb, stf_flush_in;
  logic [31:0] stf_d_out;
  logic [1:0]  stf_bytes_out;
  logic        stf_dv, stf_flush_out;
  logic [31:0] out_data;
  logic [1:0]  out_bytes;
  logic        out_dv, frame_done, busy;
  logic [23:0] frame_len;
  logic        err_overrun, err_timeout, err_stray;

  stuffer_frame_ctrl #(
    .LEN_WIDTH     (24),
    .EOI_MARKER    (16'hFFD9),
    .DRAIN_TIMEOUT (63),
    .TO_WIDTH      (6)
  ) dut (
    .xclk          (xclk),
    .rst_n         (rst_n),
    .frame_start   (frame_start),
    .frame_end     (frame_end),
    .src_data      (src_data),
    .src_bytes     (src_bytes),
    .src_stb       (src_stb),
    .stf_din       (stf_din),
    .stf_bytes_in  (stf_bytes_in),
    .stf_in_stb    (stf_in_stb),
    .stf_flush_in  (stf_flush_in),
    .stf_d_out     (stf_d_out),
    .stf_bytes_out (stf_bytes_out),
    .stf_dv        (stf_dv),
    .stf_flush_out (stf_flush_out),
    .out_data      (out_data),
    .out_bytes     (out_bytes),
    .out_dv        (out_dv),
    .frame_done    (frame_done),
    .frame_len     (frame_len),
    .busy          (busy),
    .err_overrun   (err_overrun),
    .err_timeout   (err_timeout),
    .err_stray     (err_stray)
  );

  always #5 xclk = ~xclk;

  int unsigned total = 0;
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned in_cnt = 0;
  int unsigned last_in_cyc = 0;
  int unsigned flush_cyc = 0;
  int unsigned eoi_cyc = 0;

  logic [33:0] exp_q[$];
  logic [23:0] len_q[$];
  logic [7:0]  bq[$];

  bit withhold = 1'b0;
  bit inject_eoi = 1'b0;
  bit inject_next = 1'b0;
  bit flushing = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge xclk) cyc++;

  // Behavioural stuffer: escapes 0xFF with a trailing 0x00, packs MSB-first
  task automatic emit(input int n);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < n; i++) w[31-8*i -: 8] = bq.pop_front();
    stf_d_out     = w;
    stf_bytes_out = 2'(n);
    stf_dv        = 1'b1;
  endtask

  always @(negedge xclk) begin
    stf_dv        = 1'b0;
    stf_flush_out = 1'b0;
    if (!rst_n) begin
      stf_d_out     = '0;
      stf_bytes_out = '0;
      bq.delete();
      flushing    = 1'b0;
      inject_next = 1'b0;
    end else if (inject_next) begin
      inject_next   = 1'b0;
      stf_d_out     = 32'hBADBAD00;
      stf_bytes_out = 2'd0;
      stf_dv        = 1'b1;
    end else begin
      if (stf_in_stb) begin
        for (int i = 0; i < ((stf_bytes_in == 2'd0) ? 4 : int'(stf_bytes_in)); i++) begin
          bq.push_back(stf_din[31-8*i -: 8]);
          if (stf_din[31-8*i -: 8] == 8'hFF) bq.push_back(8'h00);
        end
      end
      if (stf_flush_in) flushing = 1'b1;
      if (bq.size() >= 4) begin
        emit(4);
      end else if (flushing) begin
        if (bq.size() > 0) emit(bq.size());
        if (!withhold) begin
          stf_flush_out = 1'b1;
          flushing      = 1'b0;
          if (inject_eoi) begin
            inject_eoi  = 1'b0;
            inject_next = 1'b1;
          end
        end
      end
    end
  end

  // Output monitor: scoreboard pops and event timestamps
  always @(negedge xclk) begin
    if (rst_n) begin
      if (out_dv) begin
        chk("sb_word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("sb_word", {out_data, out_bytes}, exp_q.pop_front());
        if ({out_data, out_bytes} == {32'hFFD90000, 2'd2}) eoi_cyc = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        chk("len_expected", len_q.size() != 0, 1);
        if (len_q.size() != 0) chk("frame_len", frame_len, len_q.pop_front());
      end
      if (stf_in_stb) begin
        in_cnt++;
        last_in_cyc = cyc;
      end
      if (stf_flush_in) flush_cyc = cyc;
    end
  end

  task automatic drv(input logic fs, input logic [31:0] d, input logic [1:0] b,
                     input logic s, input logic fe);
    @(negedge xclk);
    frame_start = fs;
    src_data    = d;
    src_bytes   = b;
    src_stb     = s;
    frame_end   = fe;
  endtask

  task automatic idle();
    drv(1'b0, 32'h0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_done(input int unsigned prev, input int unsigned budget);
    bit seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge xclk);
      if (done_cnt > prev) seen = 1'b1;
    end
    chk("frame_done_seen", seen, 1);
  endtask

  localparam logic [33:0] EOI_W = {32'hFFD90000, 2'd2};

  initial begin
    int unsigned prev;
    int unsigned in_prev;
    bit found;

    rst_n = 1'b0;
    frame_start = 0; frame_end = 0; src_stb = 0; src_data = '0; src_bytes = '0;
    repeat (3) @(negedge xclk);
    chk("rst_busy", busy, 0);
    chk("rst_out_dv", out_dv, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_errs", {err_overrun, err_timeout, err_stray}, 0);
    chk("rst_stf_strobes", {stf_in_stb, stf_flush_in, frame_done}, 0);
    rst_n = 1'b1;

    // Frame 1: three words, 9 bytes, no escapes
    prev = done_cnt;
    exp_q.push_back({32'hAABBCCDD, 2'd0});
    exp_q.push_back({32'h11223344, 2'd0});
    exp_q.push_back({32'h55000000, 2'd1});
    exp_q.push_back(EOI_W);
    len_q.push_back(24'd11);
    drv(1, 32'h0, 2'd0, 0, 0);
    drv(0, 32'hAABBCCDD, 2'd0, 1, 0);
    drv(0, 32'h11223344, 2'd0, 1, 0);
    drv(0, 32'h55000000, 2'd1, 1, 1);
    idle();
    wait_done(prev, 100);
    chk("t1_flush_gap", flush_cyc - last_in_cyc, 1);
    chk("t1_errs", {err_overrun, err_timeout, err_stray}, 0);
    chk("t1_sb_empty", exp_q.size(), 0);
    chk("t1_idle", busy, 0);

    // Frame 2: all-0xFF words doubled by escaping
    prev = done_cnt;
    repeat (4) exp_q.push_back({32'hFF00FF00, 2'd0});
    exp_q.push_back(EOI_W);
    len_q.push_back(24'd18);
    drv(1, 32'h0, 2'd0, 0, 0);
    drv(0, 32'hFFFFFFFF, 2'd0, 1, 0);
    drv(0, 32'hFFFFFFFF, 2'd0, 1, 1);
    idle();
    wait_done(prev, 100);
    chk("t2_errs", {err_overrun, err_timeout, err_stray}, 0);
    chk("t2_sb_empty", exp_q.size(), 0);

    // Frame 3: flush never completes, drain times out
    withhold = 1'b1;
    prev = done_cnt;
    exp_q.push_back({32'h12345678, 2'd0});
    exp_q.push_back(EOI_W);
    len_q.push_back(24'd6);
    drv(1, 32'h0, 2'd0, 0, 0);
    drv(0, 32'h12345678, 2'd0, 1, 1);
    idle();
    wait_done(prev, 200);
    chk("t3_err_timeout", err_timeout, 1);
    chk("t3_drain_to_eoi", eoi_cyc - flush_cyc, 64);
    chk("t3_other_errs", {err_overrun, err_stray}, 0);
    chk("t3_sb_empty", exp_q.size(), 0);
    withhold = 1'b0;
    repeat (2) idle();

    // Frame 4a: frame_start while in RUN
    prev = done_cnt;
    exp_q.push_back({32'hA5A5A5A5, 2'd0});
    exp_q.push_back({32'h01020000, 2'd2});
    exp_q.push_back(EOI_W);
    len_q.push_back(24'd8);
    drv(1, 32'h0, 2'd0, 0, 0);
    drv(0, 32'hA5A5A5A5, 2'd0, 1, 0);
    drv(1, 32'h0, 2'd0, 0, 0);
    drv(0, 32'h01020000, 2'd2, 1, 1);
    idle();
    wait_done(prev, 100);
    chk("t4a_overrun", err_overrun, 1);
    chk("t4a_timeout_cleared", err_timeout, 0);
    chk("t4a_sb_empty", exp_q.size(), 0);

    // Frame 4b: flag cleared on start, then frame_start during DONE
    prev = done_cnt;
    exp_q.push_back({32'h31323334, 2'd0});
    exp_q.push_back(EOI_W);
    len_q.push_back(24'd6);
    drv(1, 32'h0, 2'd0, 0, 0);
    idle();
    chk("t4b_overrun_cleared", err_overrun, 0);
    drv(0, 32'h31323334, 2'd0, 1, 1);
    idle();
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge xclk);
      if (out_dv && out_data == 32'hFFD90000) found = 1'b1;
    end
    chk("t4b_eoi_seen", found, 1);
    frame_start = 1'b1;
    @(negedge xclk);
    frame_start = 1'b0;
    wait_done(prev, 20);
    chk("t4b_overrun_done", err_overrun, 1);
    chk("t4b_no_restart", busy, 0);
    chk("t4b_sb_empty", exp_q.size(), 0);

    // Stray upstream word in IDLE
    in_prev = in_cnt;
    drv(0, 32'hDEADBEEF, 2'd0, 1, 0);
    idle();
    chk("t5_stray_idle", err_stray, 1);
    repeat (3) idle();
    chk("t5_not_forwarded", in_cnt - in_prev, 0);
    chk("t5_no_output", exp_q.size(), 0);

    // Frame 5: stuffer output during EOI is dropped
    inject_eoi = 1'b1;
    prev = done_cnt;
    exp_q.push_back({32'h0A0B0C00, 2'd3});
    exp_q.push_back(EOI_W);
    len_q.push_back(24'd5);
    drv(1, 32'h0, 2'd0, 0, 0);
    idle();
    chk("t5b_flags_cleared", {err_overrun, err_stray}, 0);
    drv(0, 32'h0A0B0C0D, 2'd3, 1, 1);
    idle();
    wait_done(prev, 100);
    chk("t5b_stray_eoi", err_stray, 1);
    chk("t5b_sb_empty", exp_q.size(), 0);

    // Frame 6: reset while draining abandons the frame
    withhold = 1'b1;
    exp_q.push_back({32'hCAFEBABE, 2'd0});
    drv(1, 32'h0, 2'd0, 0, 0);
    drv(0, 32'hCAFEBABE, 2'd0, 1, 1);
    idle();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge xclk);
      if (stf_flush_in) found = 1'b1;
    end
    chk("t6_flush_seen", found, 1);
    repeat (5) @(negedge xclk);
    prev = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy_async", busy, 0);
    chk("t6_outs_async", {out_dv, frame_done, stf_in_stb, stf_flush_in}, 0);
    chk("t6_len_async", frame_len, 0);
    @(negedge xclk);
    @(negedge xclk);
    rst_n = 1'b1;
    withhold = 1'b0;
    repeat (5) @(negedge xclk);
    chk("t6_no_done", done_cnt - prev, 0);
    chk("t6_sb_empty", exp_q.size(), 0);
    chk("t6_errs", {err_overrun, err_timeout, err_stray}, 0);

    // Frame 7: normal frame after reset, one escape
    prev = done_cnt;
    exp_q.push_back({32'h01234567, 2'd0});
    exp_q.push_back({32'h00FF0011, 2'd0});
    exp_q.push_back(EOI_W);
    len_q.push_back(24'd10);
    drv(1, 32'h0, 2'd0, 0, 0);
    drv(0, 32'h01234567, 2'd0, 1, 0);
    drv(0, 32'h00FF1100, 2'd3, 1, 1);
    idle();
    wait_done(prev, 100);
    chk("t7_errs", {err_overrun, err_timeout, err_stray}, 0);
    chk("t7_sb_empty", exp_q.size(), 0);
    chk("t7_len_q_empty", len_q.size(), 0);

    repeat (2) @(negedge xclk);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
